// File: rtl/avalon_ibex_bus_arbiter_if.sv
// avalon_ibex_bus_arbiter_if
//   Bundles the two ibex-side Avalon-MM slave ports (instruction, data) and
//   the shared Avalon-MM master port that the arbiter drives.
//
//   Handshake: a transfer is presented when read or write is high and is
//   accepted on the cycle its waitrequest is low; address/data must be held
//   stable while waitrequest is high. Read data returns later, in order,
//   qualified by readdatavalid.
//
//   modport master : arbiter view (drives avm_* and the avs_* returns)
//   modport slave  : environment view (drives requests and slave returns)
interface avalon_ibex_bus_arbiter_if;
    // instruction side
    logic        avs_instr_read;
    logic [31:0] avs_instr_address;
    logic        avs_instr_waitrequest;
    logic        avs_instr_readdatavalid;
    logic [31:0] avs_instr_readdata;
    // data side
    logic        avs_data_read;
    logic        avs_data_write;
    logic [31:0] avs_data_address;
    logic [3:0]  avs_data_byteenable;
    logic [31:0] avs_data_writedata;
    logic        avs_data_waitrequest;
    logic        avs_data_readdatavalid;
    logic [31:0] avs_data_readdata;
    logic [1:0]  avs_data_response;
    // shared master port
    logic [31:0] avm_address;
    logic [3:0]  avm_byteenable;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;
    logic        avm_readdatavalid;
    logic [31:0] avm_readdata;
    logic [1:0]  avm_response;

    modport master (
        input  avs_instr_read, avs_instr_address,
        output avs_instr_waitrequest, avs_instr_readdatavalid, avs_instr_readdata,
        input  avs_data_read, avs_data_write, avs_data_address,
        input  avs_data_byteenable, avs_data_writedata,
        output avs_data_waitrequest, avs_data_readdatavalid, avs_data_readdata,
        output avs_data_response,
        output avm_address, avm_byteenable, avm_read, avm_write, avm_writedata,
        input  avm_waitrequest, avm_readdatavalid, avm_readdata, avm_response
    );

    modport slave (
        output avs_instr_read, avs_instr_address,
        input  avs_instr_waitrequest, avs_instr_readdatavalid, avs_instr_readdata,
        output avs_data_read, avs_data_write, avs_data_address,
        output avs_data_byteenable, avs_data_writedata,
        input  avs_data_waitrequest, avs_data_readdatavalid, avs_data_readdata,
        input  avs_data_response,
        input  avm_address, avm_byteenable, avm_read, avm_write, avm_writedata,
        output avm_waitrequest, avm_readdatavalid, avm_readdata, avm_response
    );
endinterface

// File: rtl/avalon_ibex_bus_arbiter.sv
// avalon_ibex_bus_arbiter
//   Shares one Avalon-MM master port between the ibex instruction-side (I,
//   read only) and data-side (D, read/write) masters. A stalled transfer locks
//   the grant until it is accepted. Accepted reads push their source ID into
//   an in-order tracker so each readdatavalid beat is routed to its issuer.
//
//   Optional feature: define AVALON_ARB_ROUND_ROBIN_EN for round-robin tie
//   breaking; otherwise D has fixed priority over I.
//
//   Ports:
//     clock, reset    : clock, asynchronous active-high reset
//     bus             : avalon_ibex_bus_arbiter_if.master (requests + shared port)
//     err_spurious_o  : sticky, a read return arrived with no read pending
//     dbg_locked      : grant lock state
//     dbg_owner       : lock owner (1 = D, 0 = I)
//     dbg_count       : number of outstanding reads
module avalon_ibex_bus_arbiter #(
    parameter int MAX_PENDING = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    avalon_ibex_bus_arbiter_if.master    bus,
    output logic                         err_spurious_o,
    output logic                         dbg_locked,
    output logic                         dbg_owner,
    output logic [$clog2(MAX_PENDING):0] dbg_count
);
    localparam int PW = $clog2(MAX_PENDING);
    localparam int CW = PW + 1;

    typedef enum logic {REQ_I = 1'b0, REQ_D = 1'b1} req_e;

    logic                   locked_q, locked_d;
    req_e                   owner_q, owner_d;
    logic [CW-1:0]          count_q;
    logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [MAX_PENDING-1:0] id_mem_q;
    logic                   err_q;

    logic full, empty, i_ok, d_ok, sel_valid, present, accept, push, pop;
    req_e sel, tie_winner, head;

    // A full tracker blocks new reads even when a return pops in the same
    // cycle, so the decision depends only on registered state.
    assign full  = (count_q == CW'(MAX_PENDING));
    assign empty = (count_q == '0);
    assign i_ok  = bus.avs_instr_read & ~full;
    assign d_ok  = (bus.avs_data_read | bus.avs_data_write) & ~(bus.avs_data_read & full);

`ifdef AVALON_ARB_ROUND_ROBIN_EN
    req_e last_grant_q;
    assign tie_winner = (last_grant_q == REQ_I) ? REQ_D : REQ_I;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)       last_grant_q <= REQ_I;
        else if (accept) last_grant_q <= sel;
    end
`else
    assign tie_winner = REQ_D;
`endif

    always_comb begin
        sel       = REQ_D;
        sel_valid = 1'b0;
        if (locked_q) begin
            sel       = owner_q;
            sel_valid = (owner_q == REQ_D) ? d_ok : i_ok;
        end else if (i_ok && d_ok) begin
            sel       = tie_winner;
            sel_valid = 1'b1;
        end else if (d_ok) begin
            sel       = REQ_D;
            sel_valid = 1'b1;
        end else if (i_ok) begin
            sel       = REQ_I;
            sel_valid = 1'b1;
        end
    end

    assign present = sel_valid & ~reset;
    assign accept  = present & ~bus.avm_waitrequest;

    // Request path
    assign bus.avm_address    = (sel == REQ_D) ? bus.avs_data_address : bus.avs_instr_address;
    assign bus.avm_byteenable = (sel == REQ_D) ? bus.avs_data_byteenable : 4'hF;
    assign bus.avm_writedata  = (sel == REQ_D) ? bus.avs_data_writedata : 32'h0;
    assign bus.avm_read       = present & ((sel == REQ_D) ? bus.avs_data_read : 1'b1);
    assign bus.avm_write      = present & (sel == REQ_D) & bus.avs_data_write;

    assign bus.avs_instr_waitrequest = ~(present && sel == REQ_I) | bus.avm_waitrequest;
    assign bus.avs_data_waitrequest  = ~(present && sel == REQ_D) | bus.avm_waitrequest;

    // Return path
    assign push = accept & bus.avm_read;
    assign pop  = bus.avm_readdatavalid & ~empty & ~reset;
    assign head = req_e'(id_mem_q[rd_ptr_q]);

    assign bus.avs_instr_readdatavalid = pop & (head == REQ_I);
    assign bus.avs_data_readdatavalid  = pop & (head == REQ_D);
    assign bus.avs_instr_readdata      = bus.avm_readdata;
    assign bus.avs_data_readdata       = bus.avm_readdata;
    assign bus.avs_data_response       = bus.avm_response;

    // Grant lock: set while the selected transfer stalls, dropped on
    // acceptance or when the owner withdraws its request.
    always_comb begin
        locked_d = 1'b0;
        owner_d  = owner_q;
        if (present && bus.avm_waitrequest) begin
            locked_d = 1'b1;
            owner_d  = sel;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            locked_q <= 1'b0;
            owner_q  <= REQ_D;
        end else begin
            locked_q <= locked_d;
            owner_q  <= owner_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            id_mem_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (push) begin
                id_mem_q[wr_ptr_q] <= sel;
                wr_ptr_q           <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
            if (bus.avm_readdatavalid && empty) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_spurious_o = err_q;
    assign dbg_locked     = locked_q;
    assign dbg_owner      = owner_q;
    assign dbg_count      = count_q;
endmodule
